// File: rtl/sync_fifo_param_pkg.sv
// Shared constants and elaboration helpers for the single-clock FIFO and its RAM.
// Parameter legality is checked here so every user of the FIFO applies the same rule.
package sync_fifo_param_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  // Smallest n with 2**n >= value; a depth of 1 still gets a one-bit index.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  // Depth must be a power of two (pointer wrap relies on it) and the
  // almost-empty band must sit strictly below the almost-full band.
  function automatic bit params_legal(input int depth, input int aempty_th, input int afull_th);
    return (depth >= 2) && is_pow2(depth) && (aempty_th < afull_th) && (afull_th <= depth);
  endfunction

endpackage

// File: rtl/sync_fifo_param_ram.sv
// Simple dual-port RAM: one synchronous write port and one enabled, registered read port.
// No reset on the array or read register so the storage maps onto block RAM.
module dual_port_ram
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;

  // Read-before-write on a shared address: the read returns the old word,
  // which is what a full FIFO doing a simultaneous read and write needs.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO over a dual-port RAM with occupancy count, status flags,
// a registered read path with valid strobe, and overflow/underflow pulses.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  localparam int ADDR_W   = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  generate
    if (!params_legal(DEPTH, AEMPTY_TH, AFULL_TH)) begin : g_bad_params
      $error("sync_fifo_param: illegal DEPTH/AEMPTY_TH/AFULL_TH combination");
    end
  endgenerate

  localparam logic [ADDR_W:0] DEPTH_CNT  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AFULL_CNT  = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_CNT = AEMPTY_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] PTR_ONE    = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]   wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W:0]   rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              dout_valid_reg;
  logic              dout_loaded_reg;
  logic              overflow_reg;
  logic              underflow_reg;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] ram_rd_data;

  assign full         = (count_reg == DEPTH_CNT);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= AFULL_CNT);
  assign almost_empty = (count_reg <= AEMPTY_CNT);

  // No fall-through: an empty FIFO never accepts a read, but a full one
  // makes room for a write when a read is accepted in the same cycle.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (wr_acc) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end
    // Pointers run modulo 2*DEPTH, so their difference is the occupancy:
    // +1 on a lone write, -1 on a lone read, unchanged otherwise.
    count_next = wr_ptr_next - rd_ptr_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      dout_valid_reg  <= 1'b0;
      dout_loaded_reg <= 1'b0;
      overflow_reg    <= 1'b0;
      underflow_reg   <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      dout_valid_reg <= rd_acc;
      overflow_reg   <= wr_en && !wr_acc;
      underflow_reg  <= rd_en && !rd_acc;
      if (rd_acc) begin
        dout_loaded_reg <= 1'b1;
      end
    end
  end

  dual_port_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_reg[ADDR_W-1:0]),
    .wr_data (din),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_reg[ADDR_W-1:0]),
    .rd_data (ram_rd_data)
  );

  // The RAM read register has no reset; mask it to zero until the first
  // accepted read after reset so dout still comes out of reset as 0.
  assign dout       = dout_loaded_reg ? ram_rd_data : '0;
  assign dout_valid = dout_valid_reg;
  assign count      = count_reg;
  assign overflow   = overflow_reg;
  assign underflow  = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DATA_W=8, DEPTH=16, AFULL_TH=14, AEMPTY_TH=2).
// Inputs change 1 ns after each rising edge; outputs are checked at the same point.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       dout_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge clk);
    #1;
    $display("txn t=%0t wr=%0b din=%02h rd=%0b -> dout=%02h v=%0b cnt=%0d f=%0b e=%0b af=%0b ae=%0b ovf=%0b unf=%0b",
             $time, w, d, r, dout, dout_valid, count, full, empty, almost_full, almost_empty,
             overflow, underflow);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_afull", almost_full, 0);
    check("rst_aempty", almost_empty, 1);
    check("rst_dout", dout, 8'h00);
    check("rst_valid", dout_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    rst_n = 1'b1;

    // Fill with 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      check("fill_count", count, i + 1);
      check("fill_afull", almost_full, (i + 1) >= 14);
      check("fill_aempty", almost_empty, (i + 1) <= 2);
      check("fill_full", full, i == 15);
      check("fill_empty", empty, 0);
    end
    cycle(1'b1, 8'hFF, 1'b0);
    check("ovf_pulse", overflow, 1);
    check("ovf_count", count, 16);
    cycle(1'b0, 8'h00, 1'b0);
    check("ovf_clear", overflow, 0);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      check("drain_dout", dout, i);
      check("drain_valid", dout_valid, 1);
      check("drain_count", count, 15 - i);
    end
    check("drain_empty", empty, 1);
    cycle(1'b0, 8'h00, 1'b1);
    check("unf_pulse", underflow, 1);
    check("unf_valid", dout_valid, 0);
    check("unf_dout_hold", dout, 8'h0F);
    cycle(1'b0, 8'h00, 1'b0);
    check("unf_clear", underflow, 0);

    // Simultaneous write/read while empty: write wins, read rejected
    cycle(1'b1, 8'hA5, 1'b1);
    check("es_unf", underflow, 1);
    check("es_count", count, 1);
    check("es_valid", dout_valid, 0);
    check("es_ovf", overflow, 0);
    cycle(1'b0, 8'h00, 1'b1);
    check("es_dout", dout, 8'hA5);
    check("es_rvalid", dout_valid, 1);
    check("es_empty", empty, 1);

    // Simultaneous write/read while full
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(8'h10 + i), 1'b0);
    end
    check("fs_prefull", full, 1);
    cycle(1'b1, 8'h5A, 1'b1);
    check("fs_ovf", overflow, 0);
    check("fs_full", full, 1);
    check("fs_count", count, 16);
    check("fs_dout", dout, 8'h10);
    check("fs_valid", dout_valid, 1);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      check("fs_drain", dout, (i < 15) ? (32'h11 + i) : 32'h5A);
      check("fs_drain_count", count, 15 - i);
    end
    check("fs_empty", empty, 1);

    // Wrap-around: write every cycle, read the previous word in the same cycle
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'(8'h80 + i), i > 0);
      check("wrap_count", count, 1);
      if (i > 0) begin
        check("wrap_dout", dout, 32'h80 + i - 1);
        check("wrap_valid", dout_valid, 1);
      end
    end
    cycle(1'b0, 8'h00, 1'b1);
    check("wrap_last", dout, 8'hA7);
    check("wrap_empty", empty, 1);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'(8'h60 + i), 1'b0);
    end
    cycle(1'b0, 8'h00, 1'b1);
    check("mb_dout", dout, 8'h60);
    check("mb_count", count, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_valid", dout_valid, 0);
    check("arst_dout", dout, 8'h00);
    check("arst_aempty", almost_empty, 1);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 8'h77, 1'b0);
    check("post_count", count, 1);
    cycle(1'b0, 8'h00, 1'b1);
    check("post_dout", dout, 8'h77);
    check("post_valid", dout_valid, 1);
    check("post_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
